// File: rtl/core_sequencer.sv
// ============================================================================
// Module   : core_sequencer
// Purpose  : Multi-cycle instruction sequencer (fetch/decode/execute/mem/wb),
//            owning the program counter. Optional PAUSE hint state enabled
//            by defining RISCUIN_ZIHINTPAUSE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module core_sequencer #(
    parameter int INSTR_ADDR_WIDTH = 8,
    parameter int RESET_VECTOR     = 0,
    parameter int PAUSE_CYCLES     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rb_ready,
    input  logic                        ifetch_ack,
    input  logic                        is_branch,
    input  logic                        branch_taken,
    input  logic                        load_pc,
    input  logic                        mem_r,
    input  logic                        mem_w,
    input  logic                        reg_w_dec,
    input  logic                        pause_hint,
    input  logic                        bus_ready,
    input  logic                        bus_busy,
    input  logic [INSTR_ADDR_WIDTH-1:0] pc_target,
    output logic [INSTR_ADDR_WIDTH-1:0] pc,
    output logic [INSTR_ADDR_WIDTH-1:0] pc_plus,
    output logic                        ifetch_req,
    output logic                        instr_le,
    output logic                        bus_req,
    output logic                        bus_we,
    output logic                        reg_w,
    output logic                        retired,
    output logic                        pause_active,
    output logic                        pc_end,
    output logic [2:0]                  state
);

    typedef enum logic [2:0] {
        S_RESET_WAIT = 3'd0,
        S_FETCH      = 3'd1,
        S_DECODE     = 3'd2,
        S_EXECUTE    = 3'd3,
        S_MEM        = 3'd4,
        S_WRITEBACK  = 3'd5,
        S_PAUSE      = 3'd6,
        S_HALT       = 3'd7
    } state_t;

    localparam logic [INSTR_ADDR_WIDTH-1:0] c_reset_pc = INSTR_ADDR_WIDTH'(RESET_VECTOR);
    localparam logic [INSTR_ADDR_WIDTH-1:0] c_pc_one   = INSTR_ADDR_WIDTH'(1);

    state_t                        r_state;
    logic [INSTR_ADDR_WIDTH-1:0]   r_pc;
    logic                          r_ifetch_req;
    logic                          r_instr_le;
    logic                          r_bus_req;
    logic                          r_bus_we;
    logic                          r_reg_w;
    logic                          r_retired;
    logic                          r_pause_active;
    logic                          r_pc_end;
    // Set when the instruction now in WRITEBACK came through PAUSE (retires as NOP)
    logic                          r_nop;

    logic [INSTR_ADDR_WIDTH-1:0]   w_pc_plus;
    logic                          w_jump;
    logic                          w_pc_max;
    logic                          w_abort;

    assign w_pc_plus = r_pc + c_pc_one;
    assign w_jump    = !r_nop && ((is_branch && branch_taken) || load_pc);
    assign w_pc_max  = &r_pc;
    // HALT is sticky until rst, so a dropped rb_ready only aborts live states
    assign w_abort   = !rb_ready && (r_state != S_RESET_WAIT) && (r_state != S_HALT);

`ifdef RISCUIN_ZIHINTPAUSE_EN
    localparam logic [7:0] c_pause_load = 8'(PAUSE_CYCLES - 1);
    logic [7:0] r_pause_cnt;
`else
    logic [7:0] w_unused_pause;
    assign w_unused_pause = {7'd0, pause_hint} ^ 8'(PAUSE_CYCLES);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_RESET_WAIT;
            r_pc           <= c_reset_pc;
            r_ifetch_req   <= 1'b0;
            r_instr_le     <= 1'b0;
            r_bus_req      <= 1'b0;
            r_bus_we       <= 1'b0;
            r_reg_w        <= 1'b0;
            r_retired      <= 1'b0;
            r_pause_active <= 1'b0;
            r_pc_end       <= 1'b0;
            r_nop          <= 1'b0;
`ifdef RISCUIN_ZIHINTPAUSE_EN
            r_pause_cnt    <= 8'd0;
`endif
        end else if (w_abort) begin
            r_state        <= S_RESET_WAIT;
            r_pc           <= c_reset_pc;
            r_ifetch_req   <= 1'b0;
            r_instr_le     <= 1'b0;
            r_bus_req      <= 1'b0;
            r_bus_we       <= 1'b0;
            r_reg_w        <= 1'b0;
            r_retired      <= 1'b0;
            r_pause_active <= 1'b0;
            r_nop          <= 1'b0;
        end else begin
            r_instr_le <= 1'b0;
            r_reg_w    <= 1'b0;
            r_retired  <= 1'b0;
            case (r_state)
                S_RESET_WAIT: begin
                    if (rb_ready) begin
                        r_state      <= S_FETCH;
                        r_ifetch_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (ifetch_ack) begin
                        r_state      <= S_DECODE;
                        r_ifetch_req <= 1'b0;
                        r_instr_le   <= 1'b1;
                    end
                end
                S_DECODE: begin
`ifdef RISCUIN_ZIHINTPAUSE_EN
                    if (pause_hint) begin
                        r_state        <= S_PAUSE;
                        r_pause_active <= 1'b1;
                        r_pause_cnt    <= c_pause_load;
                    end else begin
                        r_state <= S_EXECUTE;
                    end
`else
                    r_state <= S_EXECUTE;
`endif
                end
                S_EXECUTE: begin
                    if (mem_r || mem_w) begin
                        r_state   <= S_MEM;
                        r_bus_req <= 1'b1;
                        r_bus_we  <= mem_w;
                    end else begin
                        r_state   <= S_WRITEBACK;
                        r_reg_w   <= reg_w_dec;
                        r_retired <= 1'b1;
                        r_nop     <= 1'b0;
                    end
                end
                S_MEM: begin
                    if (bus_ready && !bus_busy) begin
                        r_state   <= S_WRITEBACK;
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_reg_w   <= reg_w_dec;
                        r_retired <= 1'b1;
                        r_nop     <= 1'b0;
                    end else begin
                        r_bus_we  <= mem_w;
                    end
                end
                S_PAUSE: begin
`ifdef RISCUIN_ZIHINTPAUSE_EN
                    if (r_pause_cnt == 8'd0) begin
                        r_state        <= S_WRITEBACK;
                        r_pause_active <= 1'b0;
                        r_retired      <= 1'b1;
                        r_nop          <= 1'b1;
                    end else begin
                        r_pause_cnt <= r_pause_cnt - 8'd1;
                    end
`else
                    r_state   <= S_WRITEBACK;
                    r_retired <= 1'b1;
                    r_nop     <= 1'b1;
`endif
                end
                S_WRITEBACK: begin
                    r_nop <= 1'b0;
                    if (w_jump) begin
                        r_pc         <= pc_target;
                        r_state      <= S_FETCH;
                        r_ifetch_req <= 1'b1;
                    end else if (w_pc_max) begin
                        // Sequential step off the top of memory: freeze at last word
                        r_state  <= S_HALT;
                        r_pc_end <= 1'b1;
                    end else begin
                        r_pc         <= w_pc_plus;
                        r_state      <= S_FETCH;
                        r_ifetch_req <= 1'b1;
                    end
                end
                S_HALT: begin
                    r_pc_end <= 1'b1;
                end
            endcase
        end
    end

    assign pc           = r_pc;
    assign pc_plus      = w_pc_plus;
    assign ifetch_req   = r_ifetch_req;
    assign instr_le     = r_instr_le;
    assign bus_req      = r_bus_req;
    assign bus_we       = r_bus_we;
    assign reg_w        = r_reg_w;
    assign retired      = r_retired;
    assign pause_active = r_pause_active;
    assign pc_end       = r_pc_end;
    assign state        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_core_sequencer.sv
// ============================================================================
// Module   : tb_core_sequencer
// Purpose  : Scoreboard bench for core_sequencer (ALU, load/store, branch,
//            pause, abort and pc wrap to HALT).
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_core_sequencer;

    localparam int W  = 8;
    localparam int PC = 16;
`ifdef RISCUIN_ZIHINTPAUSE_EN
    localparam bit c_pause_on = 1'b1;
`else
    localparam bit c_pause_on = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, rb_ready, ifetch_ack;
    logic         is_branch, branch_taken, load_pc;
    logic         mem_r, mem_w, reg_w_dec, pause_hint;
    logic         bus_ready, bus_busy;
    logic [W-1:0] pc_target, pc, pc_plus;
    logic         ifetch_req, instr_le, bus_req, bus_we, reg_w, retired, pause_active, pc_end;
    logic [2:0]   state;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int           lat;
        logic         regw;
        int           bus_cyc;
        logic         we;
        int           pause_cyc;
        logic [W-1:0] pc_next;
        logic [2:0]   st_next;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] model_pc;
    int           busy_left;

    always #5 clk = ~clk;

    core_sequencer #(
        .INSTR_ADDR_WIDTH (W),
        .RESET_VECTOR     (0),
        .PAUSE_CYCLES     (PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rb_ready     (rb_ready),
        .ifetch_ack   (ifetch_ack),
        .is_branch    (is_branch),
        .branch_taken (branch_taken),
        .load_pc      (load_pc),
        .mem_r        (mem_r),
        .mem_w        (mem_w),
        .reg_w_dec    (reg_w_dec),
        .pause_hint   (pause_hint),
        .bus_ready    (bus_ready),
        .bus_busy     (bus_busy),
        .pc_target    (pc_target),
        .pc           (pc),
        .pc_plus      (pc_plus),
        .ifetch_req   (ifetch_req),
        .instr_le     (instr_le),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .reg_w        (reg_w),
        .retired      (retired),
        .pause_active (pause_active),
        .pc_end       (pc_end),
        .state        (state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction's decoder flags and push its expected outcome
    task automatic issue(input logic br, input logic tk, input logic ld, input logic mr,
                         input logic mw, input logic rwd, input logic ph,
                         input logic [W-1:0] tgt, input int busy);
        exp_t e;
        logic ps, jmp;
        is_branch = br; branch_taken = tk; load_pc = ld;
        mem_r = mr; mem_w = mw; reg_w_dec = rwd; pause_hint = ph;
        pc_target = tgt; busy_left = busy; bus_busy = 1'b0;
        ps  = ph & c_pause_on;
        jmp = !ps && ((br && tk) || ld);
        e.lat       = ps ? 3 + PC : ((mr || mw) ? 5 + busy : 4);
        e.regw      = ps ? 1'b0 : rwd;
        e.bus_cyc   = (!ps && (mr || mw)) ? 1 + busy : 0;
        e.we        = !ps && mw;
        e.pause_cyc = ps ? PC : 0;
        if (jmp) begin
            e.pc_next = tgt;
            e.st_next = 3'd1;
        end else if (model_pc == {W{1'b1}}) begin
            e.pc_next = model_pc;
            e.st_next = 3'd7;
        end else begin
            e.pc_next = model_pc + 8'd1;
            e.st_next = 3'd1;
        end
        model_pc = e.pc_next;
        sb.push_back(e);
    endtask

    // Run the current instruction from FETCH to the cycle after WRITEBACK
    task automatic complete();
        exp_t e;
        int   n, bc, pcy, le;
        logic we_seen;
        n = 1; bc = 0; pcy = 0; le = 0; we_seen = 1'b0;
        chk("fetch_req", ifetch_req, 1);
        while (!retired && n < 64) begin
            tick();
            n++;
            if (bus_req) bc++;
            if (pause_active) pcy++;
            if (instr_le) le++;
            we_seen = we_seen | bus_we;
            if (state == 3'd4 && busy_left > 0) begin
                bus_busy = 1'b1;
                busy_left--;
            end else begin
                bus_busy = 1'b0;
            end
        end
        if (!retired) chk("retire_timeout", 0, 1);
        e = sb.pop_front();
        chk("latency", n, e.lat);
        chk("reg_w", reg_w, e.regw);
        chk("bus_cycles", bc, e.bus_cyc);
        chk("bus_we", we_seen, e.we);
        chk("pause_cycles", pcy, e.pause_cyc);
        chk("instr_le", le, 1);
        tick();
        chk("retire_pulse", retired, 0);
        chk("pc_next", pc, e.pc_next);
        chk("state_next", state, e.st_next);
    endtask

    initial begin
        rst = 1'b1; rb_ready = 1'b1; ifetch_ack = 1'b0;
        is_branch = 1'b0; branch_taken = 1'b0; load_pc = 1'b0;
        mem_r = 1'b0; mem_w = 1'b0; reg_w_dec = 1'b0; pause_hint = 1'b0;
        bus_ready = 1'b1; bus_busy = 1'b0; pc_target = '0;
        model_pc = '0; busy_left = 0;

        // Reset for two clocks, then one RESET_WAIT cycle before FETCH
        tick();
        tick();
        chk("rst_state", state, 0);
        chk("rst_pc", pc, 0);
        chk("rst_ifetch_req", ifetch_req, 0);
        chk("rst_pc_end", pc_end, 0);
        chk("rst_pause_active", pause_active, 0);
        rst = 1'b0;
        chk("wait_state", state, 0);
        tick();
        chk("fetch_state", state, 1);
        chk("fetch_pc", pc, 0);
        chk("fetch_req0", ifetch_req, 1);

        // ALU stream at pc 0..3
        ifetch_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(0, 0, 0, 0, 0, 1, 0, 8'h00, 0);
            complete();
        end

        // Load with three busy cycles at pc 4
        issue(0, 0, 0, 1, 0, 1, 0, 8'h00, 3);
        complete();

        // Taken branch at pc 5 to 0x20
        chk("pc_before_branch", pc, 5);
        issue(1, 1, 0, 0, 0, 0, 0, 8'h20, 0);
        complete();
        chk("pc_plus_after_branch", pc_plus, 8'h21);

        // Both mem flags: store wins, no wait
        issue(0, 0, 0, 1, 1, 0, 0, 8'h00, 0);
        complete();

        // Not-taken branch falls through
        issue(1, 0, 0, 0, 0, 1, 0, 8'h77, 0);
        complete();

        // Pause hint
        issue(0, 0, 0, 0, 0, 0, 1, 8'h00, 0);
        complete();

        // Abort: drop rb_ready in the middle of a stalled MEM access
        is_branch = 1'b0; branch_taken = 1'b0; load_pc = 1'b0; pause_hint = 1'b0;
        mem_r = 1'b1; mem_w = 1'b0; bus_busy = 1'b1;
        for (int i = 0; i < 8 && state != 3'd4; i++) tick();
        chk("abort_in_mem", state, 4);
        tick();
        chk("abort_bus_req", bus_req, 1);
        rb_ready = 1'b0;
        tick();
        chk("abort_state", state, 0);
        chk("abort_bus_req_off", bus_req, 0);
        chk("abort_pc", pc, 0);
        chk("abort_retired", retired, 0);
        mem_r = 1'b0; bus_busy = 1'b0; rb_ready = 1'b1;
        model_pc = 8'h00;
        tick();
        chk("abort_refetch", state, 1);

        // Jump to the last word, then step off the top
        issue(0, 0, 1, 0, 0, 0, 0, 8'hFF, 0);
        complete();
        issue(0, 0, 0, 0, 0, 1, 0, 8'h00, 0);
        complete();
        chk("wrap_pc_end", pc_end, 1);
        for (int i = 0; i < 3; i++) tick();
        chk("halt_sticky_state", state, 7);
        chk("halt_sticky_pc", pc, 8'hFF);
        chk("halt_sticky_end", pc_end, 1);

        // rst leaves HALT
        rst = 1'b1;
        tick();
        chk("halt_rst_state", state, 0);
        chk("halt_rst_pc_end", pc_end, 0);
        chk("halt_rst_pc", pc, 0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
